// File: rtl/ap3_fifo_reader_if.sv
// rtl/ap3_fifo_reader_if.sv - AP3 FIFO read port, flush control and output stream bundle
interface ap3_fifo_reader_if #(
    parameter int DATA_W = 32
) ();
    logic              EN;
    logic              FLUSH_REQ;
    logic [3:0]        FFLAGS;
    logic [DATA_W-1:0] RDATA;
    logic              REN;
    logic              FFLUSH;
    logic [DATA_W-1:0] M_DATA;
    logic              M_VALID;
    logic              M_READY;
    logic              BUSY;
    logic [15:0]       WORDS;

    modport master (
        input  EN,
        input  FLUSH_REQ,
        input  FFLAGS,
        input  RDATA,
        input  M_READY,
        output REN,
        output FFLUSH,
        output M_DATA,
        output M_VALID,
        output BUSY,
        output WORDS
    );

    modport slave (
        output EN,
        output FLUSH_REQ,
        output FFLAGS,
        output RDATA,
        output M_READY,
        input  REN,
        input  FFLUSH,
        input  M_DATA,
        input  M_VALID,
        input  BUSY,
        input  WORDS
    );
endinterface

// File: rtl/ap3_fifo_reader.sv
// rtl/ap3_fifo_reader.sv - AP3 FIFO-mode read controller with credit-protected skid buffer
module ap3_fifo_reader #(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic              RCLK,
    input  logic              RSTN,
    ap3_fifo_reader_if.master bus
);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam int SUM_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [RD_LATENCY-1:0] ren_hist_q, ren_hist_d;
    logic [DATA_W-1:0]     skid_mem_q [SKID_DEPTH];
    logic [DATA_W-1:0]     skid_mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      skid_count_q, skid_count_d;
    logic [15:0]           words_q, words_d;
    logic                  fflush_q, fflush_d;

    logic [INF_W-1:0]      inflight;
    logic [SUM_W-1:0]      occupancy;
    logic                  credit_ok;
    logic                  ren;
    logic                  flushing;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  m_valid;
    logic                  unused_flags;

    assign unused_flags = ^bus.FFLAGS[3:1];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(ren_hist_q[i]);
        end
    end

    // Reads in flight reserve buffer space, so backpressure can never overflow the skid buffer.
    assign occupancy = SUM_W'(skid_count_q) + SUM_W'(inflight);
    assign credit_ok = occupancy < SUM_W'(SKID_DEPTH);

    assign ren      = (state_q == RUN) && !bus.FFLAGS[0] && credit_ok && !bus.FLUSH_REQ;
    assign flushing = (state_q == FLUSH) || (state_q == DRAIN);
    assign capture  = ren_hist_q[RD_LATENCY-1];
    assign push     = capture && !flushing;
    assign m_valid  = (skid_count_q != '0) && !flushing;
    assign pop      = m_valid && bus.M_READY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.FLUSH_REQ) begin
                    state_d = FLUSH;
                end else if (bus.EN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.FLUSH_REQ) begin
                    state_d = FLUSH;
                end else if (!bus.EN) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_d = bus.EN ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ren_hist_d    = '0;
        ren_hist_d[0] = ren;
        for (int i = 1; i < RD_LATENCY; i++) begin
            ren_hist_d[i] = ren_hist_q[i-1];
        end

        skid_mem_d   = skid_mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        skid_count_d = skid_count_q;

        if (push) begin
            skid_mem_d[wr_ptr_q] = bus.RDATA;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   skid_count_d = skid_count_q + 1'b1;
            2'b01:   skid_count_d = skid_count_q - 1'b1;
            default: skid_count_d = skid_count_q;
        endcase

        // Anything captured during FLUSH/DRAIN was issued before the flush and is dropped.
        if (state_q == FLUSH) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            skid_count_d = '0;
        end

        words_d  = words_q + 16'(pop);
        fflush_d = (state_d == FLUSH);
    end

    always_ff @(posedge RCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            ren_hist_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            skid_count_q <= '0;
            words_q      <= '0;
            fflush_q     <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ren_hist_q   <= ren_hist_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            skid_count_q <= skid_count_d;
            words_q      <= words_d;
            fflush_q     <= fflush_d;
            skid_mem_q   <= skid_mem_d;
        end
    end

    assign bus.REN     = ren;
    assign bus.FFLUSH  = fflush_q;
    assign bus.M_DATA  = skid_mem_q[rd_ptr_q];
    assign bus.M_VALID = m_valid;
    assign bus.WORDS   = words_q;
    assign bus.BUSY    = (state_q != IDLE) || (inflight != '0) || (skid_count_q != '0);

endmodule

// File: tb/tb_ap3_fifo_reader.sv
// tb/tb_ap3_fifo_reader.sv - directed scoreboard bench for ap3_fifo_reader
module tb_ap3_fifo_reader;
    localparam int DATA_W = 32;

    logic RCLK = 1'b0;
    logic RSTN;
    always #5 RCLK = ~RCLK;

    ap3_fifo_reader_if #(.DATA_W(DATA_W)) bus ();

    ap3_fifo_reader #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (1),
        .SKID_DEPTH (4)
    ) dut (
        .RCLK (RCLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    logic [DATA_W-1:0] ram_q [$];
    logic [DATA_W-1:0] exp_q [$];
    logic              ram_empty = 1'b1;
    logic [DATA_W-1:0] rdata     = '0;
    logic              ren_s     = 1'b0;
    logic              ffl_s     = 1'b0;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int underruns = 0;
    int cyc       = 0;
    int ren_cnt   = 0;
    int ren_first = 0;
    int ren_last  = 0;
    int hs_cnt    = 0;
    int hs_first  = 0;
    int hs_last   = 0;
    int ffl_cnt   = 0;

    assign bus.FFLAGS = {3'b000, ram_empty};
    assign bus.RDATA  = rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // RAM FIFO model: REN/FFLUSH sampled mid-cycle, acted on just after the edge.
    always @(negedge RCLK) begin
        ren_s = bus.REN;
        ffl_s = bus.FFLUSH;
    end

    always @(posedge RCLK) begin
        #1;
        if (ffl_s) begin
            ram_q.delete();
        end else if (ren_s) begin
            if (ram_q.size() == 0) underruns++;
            else rdata = ram_q.pop_front();
        end
        ram_empty = (ram_q.size() == 0);
    end

    always @(negedge RCLK) begin
        cyc++;
        if (bus.REN) begin
            if (ren_cnt == 0) ren_first = cyc;
            ren_last = cyc;
            ren_cnt++;
        end
        if (bus.FFLUSH) ffl_cnt++;
        if (bus.M_VALID && bus.M_READY) begin
            if (hs_cnt == 0) hs_first = cyc;
            hs_last = cyc;
            hs_cnt++;
            if (exp_q.size() == 0) chk("sb_unexpected_word", bus.M_DATA, 32'hDEAD_DEAD);
            else chk("sb_m_data", bus.M_DATA, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge RCLK);
        #2;
    endtask

    task automatic settle();
        @(negedge RCLK);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] v);
        ram_q.push_back(v);
        exp_q.push_back(v);
        ram_empty = 1'b0;
    endtask

    task automatic clr_counts();
        ren_cnt = 0;
        hs_cnt  = 0;
        ffl_cnt = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            settle();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        RSTN          = 1'b0;
        bus.EN        = 1'b0;
        bus.FLUSH_REQ = 1'b0;
        bus.M_READY   = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_ren",     bus.REN,     0);
        chk("rst_fflush",  bus.FFLUSH,  0);
        chk("rst_m_valid", bus.M_VALID, 0);
        chk("rst_m_data",  bus.M_DATA,  0);
        chk("rst_busy",    bus.BUSY,    0);
        chk("rst_words",   bus.WORDS,   0);
        tick();
        RSTN = 1'b1;
        tick();

        // streaming: ten preloaded words at full rate
        for (int i = 0; i < 10; i++) push_word(32'(i));
        clr_counts();
        bus.M_READY = 1'b1;
        bus.EN      = 1'b1;
        drain("t1_drain", 100);
        tick();
        bus.EN = 1'b0;
        repeat (3) tick();
        settle();
        chk("t1_ren_cnt",    ren_cnt, 10);
        chk("t1_ren_contig", ren_last - ren_first + 1, 10);
        chk("t1_hs_contig",  hs_last - hs_first + 1, 10);
        chk("t1_words",      bus.WORDS, 10);
        chk("t1_busy",       bus.BUSY, 0);
        tick();

        // backpressure: only SKID_DEPTH reads until the consumer accepts
        bus.M_READY = 1'b0;
        for (int i = 0; i < 10; i++) push_word(32'hB000_0000 + 32'(i));
        clr_counts();
        bus.EN = 1'b1;
        repeat (12) tick();
        settle();
        chk("t2_ren_held", ren_cnt, 4);
        chk("t2_valid",    bus.M_VALID, 1);
        chk("t2_head",     bus.M_DATA, 32'hB000_0000);
        tick();
        bus.M_READY = 1'b1;
        drain("t2_drain", 100);
        tick();
        bus.EN = 1'b0;
        repeat (3) tick();
        settle();
        chk("t2_ren_total", ren_cnt, 10);
        chk("t2_hs_total",  hs_cnt, 10);
        chk("t2_words",     bus.WORDS, 20);
        chk("t2_busy",      bus.BUSY, 0);
        tick();

        // empty boundary: one word yields exactly one read
        bus.EN = 1'b1;
        clr_counts();
        repeat (4) tick();
        settle();
        chk("t3_no_ren_empty", ren_cnt, 0);
        tick();
        push_word(32'hCAFE_F00D);
        repeat (6) tick();
        settle();
        chk("t3_one_ren",   ren_cnt, 1);
        chk("t3_delivered", exp_q.size(), 0);
        chk("t3_words",     bus.WORDS, 21);
        tick();

        // flush with two words buffered and one in flight, colliding with a read opportunity
        bus.M_READY = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'hF000_0000 + 32'(i));
        clr_counts();
        repeat (3) tick();
        bus.FLUSH_REQ = 1'b1;
        exp_q.delete();
        settle();
        chk("t4_ren_before",  ren_cnt, 3);
        chk("t4_ren_blocked", bus.REN, 0);
        chk("t4_valid_pre",   bus.M_VALID, 1);
        tick();
        bus.FLUSH_REQ = 1'b0;
        settle();
        chk("t4_fflush_on",   bus.FFLUSH, 1);
        chk("t4_valid_flush", bus.M_VALID, 0);
        chk("t4_ren_flush",   bus.REN, 0);
        tick();
        settle();
        chk("t4_fflush_off",  bus.FFLUSH, 0);
        chk("t4_valid_drain", bus.M_VALID, 0);
        tick();
        settle();
        chk("t4_valid_after", bus.M_VALID, 0);
        chk("t4_busy_run",    bus.BUSY, 1);
        chk("t4_ffl_pulses",  ffl_cnt, 1);
        chk("t4_no_hs",       hs_cnt, 0);
        chk("t4_words",       bus.WORDS, 21);
        tick();
        bus.M_READY = 1'b1;
        push_word(32'h5A5A_5A5A);
        drain("t4_resume", 20);
        tick();
        settle();
        chk("t4_words_resume", bus.WORDS, 22);
        tick();

        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 20; i++) push_word(32'hD000_0000 + 32'(i));
        repeat (5) tick();
        settle();
        chk("t5_streaming", bus.M_VALID, 1);
        tick();
        RSTN = 1'b0;
        ram_q.delete();
        exp_q.delete();
        ram_empty = 1'b1;
        #1;
        chk("t5_rst_ren",     bus.REN,     0);
        chk("t5_rst_fflush",  bus.FFLUSH,  0);
        chk("t5_rst_m_valid", bus.M_VALID, 0);
        chk("t5_rst_m_data",  bus.M_DATA,  0);
        chk("t5_rst_busy",    bus.BUSY,    0);
        chk("t5_rst_words",   bus.WORDS,   0);
        repeat (2) tick();
        RSTN = 1'b1;
        tick();

        // handshake counter wrap
        for (int i = 0; i < 65534; i++) push_word(32'(i));
        drain("t6_drain_bulk", 70000);
        tick();
        settle();
        chk("t6_words_fffe", bus.WORDS, 32'h0000_FFFE);
        tick();
        for (int i = 0; i < 3; i++) push_word(32'hE000_0000 + 32'(i));
        drain("t6_drain_wrap", 30);
        tick();
        settle();
        chk("t6_words_wrap", bus.WORDS, 32'h0000_0001);
        tick();
        bus.EN = 1'b0;
        repeat (3) tick();
        settle();
        chk("t6_busy_end",  bus.BUSY, 0);
        chk("no_underruns", underruns, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ap3_fifo_reader.md
# ap3_fifo_reader

Read-side controller for the AP3 RAM block in FIFO mode (`FMODE=1`). It watches the FIFO flags, issues `REN` pulses, and captures `RDATA` after the fixed read latency. Captured words are presented on a valid/ready stream through a credit-protected skid buffer, so no word is ever dropped under backpressure. It also sequences FIFO flushes. It sits in fabric between the RAM read port and the downstream consumer, on the RAM's `RCLK` domain.

## Interface
- `DATA_W`, 32: width of `RDATA` and `M_DATA`.
- `RD_LATENCY`, 1: cycles from the `REN` sample edge to valid `RDATA`. Legal values are 1 and 2.
- `SKID_DEPTH`, 4: skid buffer entries. Must be ≥ `RD_LATENCY`+2.

Ports:
- `RCLK`  in  1  sole clock, rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `EN`  in  1  permits new reads.
- `FLUSH_REQ`  in  1  single-cycle request to flush the FIFO.
- `FFLAGS`  in  4  FIFO flags from the RAM: [0]=EMPTY, [1]=ALMOST_EMPTY, [2]=ALMOST_FULL, [3]=FULL. Only [0] is used for control.
- `RDATA`  in  `DATA_W`  RAM read data.
- `REN`  out  1  read enable to the RAM.
- `FFLUSH`  out  1  flush pulse to the RAM.
- `M_DATA`  out  `DATA_W`  stream data (head of the skid buffer).
- `M_VALID`  out  1  stream valid.
- `M_READY`  in  1  stream ready.
- `BUSY`  out  1  high when state ≠ IDLE, or reads are in flight, or the buffer is non-empty.
- `WORDS`  out  16  count of completed stream handshakes.

## Operation
- FSM states: IDLE, RUN, FLUSH, DRAIN.
  - IDLE→RUN: `EN`=1.
  - RUN→IDLE: `EN`=0.
  - IDLE/RUN→FLUSH: `FLUSH_REQ`=1. Takes priority over `EN`.
  - FLUSH→DRAIN: unconditional, after one cycle.
  - DRAIN→RUN if `EN`=1, else IDLE, once `inflight`=0.
- `inflight` counts reads issued whose data is not yet captured. Range 0..`RD_LATENCY`. It is a shift register of `REN` history, depth `RD_LATENCY`.
- Credit: `credit_ok` = (`skid_count` + `inflight`) < `SKID_DEPTH`. A pop in the same cycle is not counted.
- `REN` is combinational: state==RUN & !`FFLAGS[0]` & `credit_ok` & !`FLUSH_REQ`.
- `FFLAGS` contract: the flags reflect all `REN` pulses up to and including the previous cycle. Issuing `REN` whenever EMPTY=0 therefore never underruns.
- Capture: `RD_LATENCY` cycles after a `REN`-high edge, `RDATA` is pushed into the skid buffer.
  - Exception: if that read was issued before a flush (captured during FLUSH/DRAIN), the word is discarded.
- Skid buffer is a FIFO of `SKID_DEPTH` entries.
  - `M_VALID` = `skid_count`≠0 and state ∉ {FLUSH, DRAIN}.
  - `M_DATA` = head entry.
  - Pop on `M_VALID` & `M_READY`.
  - Simultaneous push and pop: count unchanged, ordering preserved.
- FLUSH cycle:
  - `FFLUSH`=1 for exactly one cycle; `REN`=0.
  - Skid buffer cleared at the end of the cycle.
  - `M_VALID`=0, including any word presented in the previous cycle. The consumer sees no handshake.
- `EN` falling in RUN: issuing stops, but in-flight words are still captured. Words already in the buffer keep draining via the stream in IDLE.
- `WORDS` increments on each handshake and wraps 0xFFFF→0x0000. It is cleared only by reset.
- `FLUSH_REQ` while in FLUSH or DRAIN: ignored.

## Timing
- Reset values (async, immediate on `RSTN`=0):
  - state=IDLE, `inflight`=0, `skid_count`=0, `WORDS`=0.
  - `REN`=0, `FFLUSH`=0, `M_VALID`=0, `M_DATA`=0, `BUSY`=0.
- Reset asserted mid-operation discards all buffered and in-flight data. `RSTN` release takes effect on the next `RCLK` edge.
- Latency with `RD_LATENCY`=1:
  - `REN` high in cycle t → word in buffer at the t+1 edge → `M_VALID` high in cycle t+2 (first word).
- Throughput: one word per cycle sustained while EMPTY=0 and `M_READY`=1.
- Backpressure: with `M_READY`=0, at most `SKID_DEPTH` words are read, then `REN` stays low.
- `FFLUSH` is registered: high in the cycle the state is FLUSH, i.e. the cycle after `FLUSH_REQ` is sampled.
- DRAIN lasts up to `RD_LATENCY` cycles.

## Test plan
- Streaming: FIFO preloaded with 0x0..0x9, `EN`=1, `M_READY`=1 → `REN` high for 10 consecutive cycles. `M_DATA` sequence is 0..9 with no gaps, then `WORDS`=10 and `BUSY`=0.
- Backpressure: 10 words preloaded, `M_READY`=0 → exactly 4 `REN` pulses, `M_VALID`=1 holding word 0. Release `M_READY` → all 10 words delivered in order, none lost or duplicated.
- Empty boundary: single word written, EMPTY falls → exactly one `REN`. Then no `REN` while EMPTY=1. `M_DATA` equals the written value.
- Flush mid-stream: `FLUSH_REQ` while 2 words are buffered and 1 in flight → `FFLUSH` high one cycle and `M_VALID`=0 through FLUSH/DRAIN. All three words discarded, `WORDS` unchanged, return to RUN.
- Simultaneous `FLUSH_REQ` and a `REN` opportunity → `REN`=0 that cycle and FLUSH entered.
- Counter wrap and reset: force `WORDS` to 0xFFFE, complete 3 handshakes → 0x0001. Assert `RSTN`=0 mid-stream → all outputs at reset values immediately.
